shift_sequencer: RTL and testbench
==================================

Name: shift_sequencer

Overview:
- Multi-cycle shift unit for the mini CPU execute stage.
- Accepts an operand, a 5-bit shift amount, a direction and an arithmetic/logical select from the decode/issue logic.
- Produces the shifted word by applying one single-bit shift step per clock.
- Signals completion to the writeback path with a one-cycle done pulse and holds the result until the next operation is accepted.

Parameters:
- WIDTH, 32, data word width in bits.
- AMT_W, 5, shift-amount width; must equal clog2(WIDTH).

Ports:
- clk  input  1  system clock, rising-edge active
- rst  input  1  asynchronous, active-high reset
- start  input  1  request to begin a shift; sampled on rising clk
- operand  input  WIDTH  value to shift; sampled on the accepting edge
- shamt  input  AMT_W  shift distance 0..WIDTH-1; sampled on the accepting edge
- left  input  1  1 = shift left (zero fill), 0 = shift right
- arith  input  1  right shifts only: 1 = replicate bit WIDTH-1, 0 = zero fill; ignored when left=1
- busy  output  1  high whenever state is not IDLE
- done  output  1  one-cycle pulse; result is valid in this cycle
- result  output  WIDTH  final shifted value; held until the next accepted start

Behaviour:
- Clock and reset: one clock (clk); rst is asynchronous and active-high.
- Reset (async, any state): state=IDLE, busy=0, done=0, result=0, internal count=0, internal data=0.
- States are IDLE, SHIFT and DONE.
- IDLE: busy=0, done=0.
  - start=1 on an edge accepts the request: data<=operand, cnt<=shamt, and left/arith are latched.
  - Next state is DONE if shamt==0, otherwise SHIFT.
  - start=0: remain in IDLE.
- SHIFT: busy=1. Each edge applies one single-bit step to data and sets cnt<=cnt-1.
  - Left step: data<={data[WIDTH-2:0],1'b0}.
  - Right step: data<={fill,data[WIDTH-1:1]}, where fill = latched_arith & data[WIDTH-1].
  - When cnt==1 on an edge, that edge performs the last step and next state is DONE.
- DONE: busy=1, done=1, result drives the final data. The next edge always goes to IDLE.
- Latency: with accept edge E0, the DONE state is entered on edge E0+shamt, or on E0 itself when shamt=0. done is high for exactly one cycle.
- result is registered from data. It stays stable from DONE until the next accepted start, including through IDLE.
- start while busy=1 is ignored: no queuing, and latched inputs are unaffected.
- A start held high across DONE->IDLE is accepted on the first edge in IDLE, so back-to-back operations are separated by at least one idle cycle.
- Changes to operand/shamt/left/arith after the accept edge have no effect.
- shamt=WIDTH-1 with arith=1 on a negative operand gives all ones.
- Fill is computed from the current data MSB each step; the sign bit never changes during an arithmetic right shift.
- Reset asserted mid-SHIFT aborts immediately. done is never asserted for the aborted operation.

Decomposition:
- Shared package shift_pkg holds:
  - WIDTH/AMT_W default constants;
  - the state enum (IDLE, SHIFT, DONE);
  - the shift-direction constants (DIR_LEFT=1, DIR_RIGHT=0).
- One sub-module is natural: shift_one_step, a combinational module with inputs data[WIDTH], left and arith, and output data shifted by exactly one bit. It is instantiated once in the datapath.
- The FSM and counter stay in shift_sequencer.

Test Plan:
- operand=0x80000000, shamt=4, left=0, arith=1 -> result=0xF8000000; done high exactly 4 edges after accept, for 1 cycle.
- Same operand, shamt=4, arith=0 -> result=0x08000000.
- operand=0x00000001, shamt=31, left=1 -> result=0x80000000; busy high for 32 cycles (31 SHIFT + 1 DONE).
- operand=0x1234ABCD, shamt=0 -> done in the cycle after accept; result=0x1234ABCD; busy high for 1 cycle.
- Start a shamt=10 right shift, then pulse start with different operand/shamt during SHIFT -> second request ignored; result is that of the first request; done pulses once.
- Assert rst mid-SHIFT after 3 steps -> busy, done and result go to 0 immediately. After release, a new start with operand=0xFFFFFFFF, shamt=1, arith=1 -> result=0xFFFFFFFF.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared constants and types for the multi-cycle shift unit.
package shift_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int AMT_W_DEF = 5;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  localparam logic DIR_LEFT  = 1'b1;
  localparam logic DIR_RIGHT = 1'b0;

endpackage

// File: rtl/shift_one_step.sv
// Combinational single-bit shift: left zero-fill, right logical or arithmetic.
module shift_one_step
  import shift_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic             left,
  input  logic             arith,
  output logic [WIDTH-1:0] data_o
);

  logic fill;

  always_comb begin
    fill = arith & data_i[WIDTH-1];
    if (left == DIR_LEFT)
      data_o = {data_i[WIDTH-2:0], 1'b0};
    else
      data_o = {fill, data_i[WIDTH-1:1]};
  end

endmodule

// File: rtl/shift_sequencer.sv
// Execute-stage shifter applying one bit step per clock,
// with a one-cycle done pulse and a held result.
module shift_sequencer
  import shift_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int AMT_W = AMT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] operand,
  input  logic [AMT_W-1:0] shamt,
  input  logic             left,
  input  logic             arith,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [AMT_W-1:0] cnt_q, cnt_d;
  logic             left_q, left_d;
  logic             arith_q, arith_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] step_out;

  shift_one_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .data_i (data_q),
    .left   (left_q),
    .arith  (arith_q),
    .data_o (step_out)
  );

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    cnt_d    = cnt_q;
    left_d   = left_q;
    arith_d  = arith_q;
    result_d = result_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          data_d  = operand;
          cnt_d   = shamt;
          left_d  = left;
          arith_d = arith;
          busy_d  = 1'b1;
          if (shamt == '0) begin
            state_d  = DONE;
            result_d = operand;
            done_d   = 1'b1;
          end else begin
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        data_d = step_out;
        cnt_d  = cnt_q - AMT_W'(1);
        busy_d = 1'b1;
        // Last step lands in result so it is valid during DONE.
        if (cnt_q == AMT_W'(1)) begin
          state_d  = DONE;
          result_d = step_out;
          done_d   = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      data_q   <= '0;
      cnt_q    <= '0;
      left_q   <= 1'b0;
      arith_q  <= 1'b0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      cnt_q    <= cnt_d;
      left_q   <= left_d;
      arith_q  <= arith_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed self-checking bench for shift_sequencer.
module tb_shift_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] operand;
  logic [4:0]  shamt;
  logic        left;
  logic        arith;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;
  int lat, bcnt, dcnt;

  shift_sequencer dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .operand (operand),
    .shamt   (shamt),
    .left    (left),
    .arith   (arith),
    .busy    (busy),
    .done    (done),
    .result  (result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic watch(input int base, output int l, output int b,
                       output int d);
    l = -1;
    b = 0;
    d = 0;
    for (int i = 0; i < 100; i++) begin
      if (!busy) break;
      b++;
      if (done) begin
        d++;
        if (l < 0) l = base + i;
      end
      @(negedge clk);
    end
    chk("timeout", {31'b0, busy}, 32'h0);
  endtask

  task automatic run(input logic [31:0] op, input logic [4:0] sh,
                     input logic l_i, input logic a_i,
                     output int l, output int b, output int d);
    @(negedge clk);
    operand = op;
    shamt   = sh;
    left    = l_i;
    arith   = a_i;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    operand = ~op;
    shamt   = ~sh;
    left    = ~l_i;
    arith   = ~a_i;
    watch(0, l, b, d);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    operand = '0;
    shamt = '0;
    left = 1'b0;
    arith = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_done", {31'b0, done}, 32'h0);
    chk("rst_result", result, 32'h0);
    rst = 1'b0;

    run(32'h8000_0000, 5'd4, 1'b0, 1'b1, lat, bcnt, dcnt);
    chk("sra4_result", result, 32'hF800_0000);
    chk("sra4_latency", lat, 32'd4);
    chk("sra4_done_cycles", dcnt, 32'd1);

    run(32'h8000_0000, 5'd4, 1'b0, 1'b0, lat, bcnt, dcnt);
    chk("srl4_result", result, 32'h0800_0000);

    run(32'h0000_0001, 5'd31, 1'b1, 1'b0, lat, bcnt, dcnt);
    chk("sll31_result", result, 32'h8000_0000);
    chk("sll31_busy", bcnt, 32'd32);

    run(32'h1234_ABCD, 5'd0, 1'b0, 1'b0, lat, bcnt, dcnt);
    chk("sh0_result", result, 32'h1234_ABCD);
    chk("sh0_latency", lat, 32'd0);
    chk("sh0_busy", bcnt, 32'd1);

    repeat (3) @(negedge clk);
    chk("idle_hold", result, 32'h1234_ABCD);

    run(32'h8000_0000, 5'd31, 1'b0, 1'b1, lat, bcnt, dcnt);
    chk("sra31_ones", result, 32'hFFFF_FFFF);

    // second start while shifting must be dropped
    @(negedge clk);
    operand = 32'hF0F0_0000;
    shamt = 5'd10;
    left = 1'b0;
    arith = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    operand = 32'h0000_0001;
    shamt = 5'd3;
    left = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    watch(3, lat, bcnt, dcnt);
    chk("ign_result", result, 32'h003C_3C00);
    chk("ign_latency", lat, 32'd10);
    chk("ign_done_cycles", dcnt, 32'd1);
    repeat (4) @(negedge clk);
    chk("ign_no_second", {31'b0, busy}, 32'h0);

    // reset after three steps
    @(negedge clk);
    operand = 32'hF0F0_0000;
    shamt = 5'd10;
    left = 1'b0;
    arith = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_busy", {31'b0, busy}, 32'h0);
    chk("abort_done", {31'b0, done}, 32'h0);
    chk("abort_result", result, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    run(32'hFFFF_FFFF, 5'd1, 1'b0, 1'b1, lat, bcnt, dcnt);
    chk("post_rst_result", result, 32'hFFFF_FFFF);
    chk("post_rst_latency", lat, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
